ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (LED set, echo, reset, …) to the keyboard over the shared open-drain PS/2 clock/data lines, where the existing WASD receiver only listens. It runs on the system clock, oversamples the device-generated PS/2 clock, and drives the lines through active-high open-drain enables. It sits between command-issuing control logic and the PS/2 pads, alongside the keyboard receiver.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_line_sync.sv | 48 ++++
 rtl/ps2_host_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 host transmitter and receiver:
//   - ps2_tx_state_e : host-to-device transmitter states
//   - PS2_CMD_* / PS2_RESP_ACK : common keyboard command and response bytes
//   - PS2_BIT_PARITY / PS2_BIT_STOP : frame positions counted in device
//     falling edges (data bits occupy edges 1..8)
//   - ps2_odd_parity() : odd parity over one byte
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  localparam int unsigned PS2_BIT_PARITY = 9;
  localparam int unsigned PS2_BIT_STOP   = 10;

  // Odd parity: the nine bits data+parity always hold an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync
//   Brings the asynchronous PS/2 clock and data pads into the system clock
//   domain and flags falling edges of the PS/2 clock.
//   Ports:
//     clock      in   system clock
//     reset      in   synchronous, active-high
//     clock_pad  in   raw PS/2 clock pad
//     data_pad   in   raw PS/2 data pad
//     clock_sync out  synchronized PS/2 clock
//     data_sync  out  synchronized PS/2 data
//     clock_fall out  high for one cycle after a synchronized clock 1->0
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic clock_pad,
  input  logic data_pad,
  output logic clock_sync,
  output logic data_sync,
  output logic clock_fall
);

  logic clock_meta;
  logic data_meta;
  logic clock_prev;

  // Idle PS/2 lines are pulled high, so the chain resets to 1 to avoid a
  // spurious falling edge coming out of reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments make every flop sample the previous
    // stage's old value, which is what turns this into a shift chain.
    if (reset) begin
      clock_meta <= 1'b1;
      clock_sync <= 1'b1;
      clock_prev <= 1'b1;
      data_meta  <= 1'b1;
      data_sync  <= 1'b1;
    end else begin
      clock_meta <= clock_pad;
      clock_sync <= clock_meta;
      clock_prev <= clock_sync;
      data_meta  <= data_pad;
      data_sync  <= data_meta;
    end
  end

  assign clock_fall = clock_prev & ~clock_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
//   shifts one command byte plus odd parity out on device-generated clock
//   falling edges, then samples the device acknowledge bit.
//   Ports:
//     clock, reset            system clock, synchronous active-high reset
//     tx_data, tx_valid       command byte and request; taken when tx_ready=1
//     tx_ready                high only in IDLE
//     ps2_clock_in/data_in    raw pads (asynchronous)
//     ps2_clock_oe/data_oe    1 = pull the open-drain line low
//     busy                    high in every state except IDLE
//     done, nack              one-cycle completion pulse; nack=1 if no ack
//     timeout                 one-cycle pulse on watchdog abort
//   Configuration:
//     PS2_TX_TIMEOUT_EN  enables the watchdog that aborts a transfer when the
//                        device stops clocking; without it timeout is 0 and a
//                        silent device stalls the block until reset.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned REQ_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       timeout
);

  localparam int unsigned DLY_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

  ps2_tx_state_e             state;
  logic [DLY_W-1:0]          dly_cnt;
  logic [3:0]                edge_cnt;   // device falling edges seen in SHIFT
  logic [3:0]                edge_num;   // number of the edge being handled now
  logic [PS2_BIT_PARITY-1:0] frame;      // {parity, data[7:0]}, LSB sent first
  logic                      clock_sync;
  logic                      data_sync;
  logic                      clock_fall;

  ps2_line_sync u_sync (
    .clock      (clock),
    .reset      (reset),
    .clock_pad  (ps2_clock_in),
    .data_pad   (ps2_data_in),
    .clock_sync (clock_sync),
    .data_sync  (data_sync),
    .clock_fall (clock_fall)
  );

  assign edge_num = edge_cnt + 4'd1;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      dly_cnt      <= '0;
      edge_cnt     <= '0;
      frame        <= '0;
      tx_ready     <= 1'b1;
      busy         <= 1'b0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      done         <= 1'b0;
      nack         <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      timeout      <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          ps2_clock_oe <= 1'b0;
          ps2_data_oe  <= 1'b0;
          if (tx_valid && tx_ready) begin
            frame        <= {ps2_odd_parity(tx_data), tx_data};
            dly_cnt      <= '0;
            ps2_clock_oe <= 1'b1;
            tx_ready     <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (dly_cnt == DLY_W'(INHIBIT_CYCLES - 1)) begin
            dly_cnt     <= '0;
            ps2_data_oe <= 1'b1;        // start bit
            state       <= ST_REQUEST;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end

        ST_REQUEST: begin
          if (dly_cnt == DLY_W'(REQ_CYCLES - 1)) begin
            ps2_clock_oe <= 1'b0;       // hand the clock to the device
            edge_cnt     <= '0;
            state        <= ST_SHIFT;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          // Updates land right after a falling edge, well before the device
          // samples on the following rising edge.
          if (clock_fall) begin
            edge_cnt <= edge_num;
            if (edge_num == 4'(PS2_BIT_STOP)) begin
              ps2_data_oe <= 1'b0;      // stop bit = released line
              state       <= ST_ACK;
            end else begin
              ps2_data_oe <= ~frame[edge_cnt];
            end
          end
        end

        ST_ACK: begin
          if (clock_fall) begin
            nack  <= data_sync;
            state <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          if (clock_sync && data_sync) begin
            done     <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        default: begin
          ps2_clock_oe <= 1'b0;
          ps2_data_oe  <= 1'b0;
          tx_ready     <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Placed after the case so an abort overrides whatever the state
      // machine scheduled in the same cycle (the last assignment wins).
      if (state inside {ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) begin
        if (clock_fall) begin
          wd_cnt <= '0;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          wd_cnt       <= '0;
          timeout      <= 1'b1;
          done         <= 1'b0;
          ps2_clock_oe <= 1'b0;
          ps2_data_oe  <= 1'b0;
          tx_ready     <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
`endif
    end
  end

endmodule
